plot_queue: RTL and testbench
=============================

Name: plot_queue

Overview:
- Sits directly downstream of the screen-fill and draw engines; consumes their per-pixel plot strobe (x, y, colour, plot).
- Range-checks each request and converts it to a linear framebuffer address, y*320 + x.
- Buffers each request in a small FIFO and issues it to the framebuffer write port under a valid/ready handshake.
- Decouples single-cycle plot pulses from a framebuffer that may stall. Provides a drain handshake so the game controller knows when every plotted pixel has landed.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- H_RES, 320: horizontal resolution; x must be < H_RES.
- V_RES, 240: vertical resolution; y must be < V_RES.
- CNT_W, 16: width of the saturating drop and out-of-range counters.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- vga_x  in  9  pixel x from the upstream plot engine.
- vga_y  in  8  pixel y from the upstream plot engine.
- vga_colour  in  3  pixel colour.
- vga_plot  in  1  plot strobe; one request per high cycle.
- fb_addr  out  17  linear framebuffer address.
- fb_data  out  3  colour to write.
- fb_we  out  1  write valid.
- fb_ready  in  1  framebuffer accepts a write this cycle.
- drain_req  in  1  level request: finish all queued writes.
- drain_done  out  1  one-cycle pulse when a drain completes.
- busy  out  1  FIFO non-empty.
- full  out  1  FIFO holds DEPTH entries.
- drop_count  out  CNT_W  saturating count of in-range requests lost to overflow.
- oob_count  out  CNT_W  saturating count of out-of-range requests.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Read and write pointers, occupancy, both counters and the FSM clear.
  - The FSM goes to RUN.
  - fb_we=0, busy=0, full=0, drain_done=0 from the next cycle.
  - Queued entries are discarded. A reset mid-transfer abandons the write; no partial state survives.
- Accept rule: vga_plot=1, vga_x<H_RES, vga_y<V_RES, and (not full, or a pop occurs in the same cycle) -> push {addr, colour}.
  - addr = vga_y*H_RES + vga_x, computed at push time in 17 bits.
  - Multiplication is by shift-add: (y<<8)+(y<<6)+x for the default 320.
- Out-of-range: vga_plot=1 with x>=H_RES or y>=V_RES -> not pushed; oob_count += 1, saturating at all-ones.
- Overflow: in-range request while full with no pop that cycle -> not pushed; drop_count += 1, saturating.
- Output side:
  - fb_we = !empty; fb_addr/fb_data = head entry.
  - Pop when fb_we && fb_ready.
  - While fb_we=1 and fb_ready=0, fb_addr/fb_data hold stable.
- Latency: a request pushed into an empty FIFO at edge N appears on fb_* in the cycle after edge N. There is no combinational bypass.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance, wrapping modulo DEPTH.
- busy = !empty; full = (occupancy == DEPTH); both registered-state derived.
- FSM, states RUN, DRAIN, DONE:
  - RUN: if drain_req=1 -> DRAIN.
  - DRAIN: pushes are still accepted. When empty, or when the last entry pops in that cycle -> DONE. drain_done pulses 1 on the cycle DONE is entered.
  - DONE: if drain_req=0 -> RUN, else stay. drain_done=0 in DONE after the entry cycle.
  - drain_req asserted while already empty in RUN: RUN->DRAIN, then DRAIN->DONE on the next edge, with the pulse.
- No request ever affects fb_* in its own cycle; the counters update at the same edge as the rejected request.

Decomposition:
- Shared package vga_pkg:
  - H_RES, V_RES localparams.
  - FB_AW=17.
  - typedef colour_t (logic [2:0]).
  - typedef plot_entry_t (struct: addr[16:0], colour_t).
  - enum for RUN/DRAIN/DONE.
- One sub-module, plot_fifo: a generic synchronous FIFO of plot_entry_t with push/pop/empty/full/count, parameterised by DEPTH.
- plot_queue holds the address calculation, range check, counters and FSM.

Test Plan:
- Reset, then plot (x=5, y=2, colour=3) with fb_ready=1 -> next cycle fb_we=1, fb_addr=645, fb_data=3; busy=0 one cycle later.
- fb_ready=0, 16 consecutive plots, then a 17th plot -> full=1 after the 16th, drop_count=1. Release fb_ready -> 16 writes in push order, addresses unchanged while stalled.
- Plots at (320,0), (0,240) and (319,239) -> oob_count=2; a single write at addr 76799.
- Full FIFO with fb_ready=1 and a plot in the same cycle -> accepted, drop_count stays 0, occupancy stays 16.
- Queue 4 entries, assert drain_req with fb_ready toggling 1/0 -> drain_done pulses exactly once, one cycle after the 4th accepted write. Deassert drain_req -> back to RUN.
- Assert rst mid-stall with 8 queued -> next cycle fb_we=0, busy=0, counters 0; a subsequent plot is written normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot path.
package vga_pkg;

  localparam int unsigned H_RES = 320;
  localparam int unsigned V_RES = 240;
  localparam int unsigned FB_AW = 17;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;

  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    colour_t          colour;
  } plot_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Linear address y*hres + x as a shift-add over the set bits of hres.
  function automatic logic [FB_AW-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y,
                                                  input int unsigned    hres);
    logic [FB_AW-1:0] acc;
    logic [FB_AW-1:0] hv;
    hv  = FB_AW'(hres);
    acc = FB_AW'(x);
    for (int i = 0; i < int'(FB_AW); i++) begin
      if (hv[i]) acc = acc + (FB_AW'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries; head entry is presented from storage.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  plot_entry_t              wr_entry,
  output plot_entry_t              rd_entry,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  plot_entry_t   mem_q [DEPTH];

  assign empty    = (count_q == CW'(0));
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign rd_entry = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; push into a full FIFO only with a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: rtl/plot_queue.sv
// Range-checks plot strobes, buffers them and issues framebuffer writes.
module plot_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned H_RES = vga_pkg::H_RES,
  parameter int unsigned V_RES = vga_pkg::V_RES,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8:0]                vga_x,
  input  logic [7:0]                vga_y,
  input  logic [2:0]                vga_colour,
  input  logic                      vga_plot,
  output logic [vga_pkg::FB_AW-1:0] fb_addr,
  output logic [2:0]                fb_data,
  output logic                      fb_we,
  input  logic                      fb_ready,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy,
  output logic                      full,
  output logic [CNT_W-1:0]          drop_count,
  output logic [CNT_W-1:0]          oob_count
);

  import vga_pkg::*;

  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic         in_range, pop, push, oob_hit, drop_hit, last_pop;
  logic         empty, fifo_full;
  logic [OW-1:0] occ;
  plot_entry_t  wr_entry, head;

  drain_state_e     state_q, state_d;
  logic             drain_done_q, drain_done_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] oob_q, oob_d;

  plot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .empty    (empty),
    .full     (fifo_full),
    .count    (occ)
  );

  // Request decode: range check, accept/reject and the entry to push.
  always_comb begin
    in_range        = (32'(vga_x) < H_RES) && (32'(vga_y) < V_RES);
    pop             = !empty && fb_ready;
    push            = vga_plot && in_range && (!fifo_full || pop);
    oob_hit         = vga_plot && !in_range;
    drop_hit        = vga_plot && in_range && fifo_full && !pop;
    last_pop        = pop && !push && (occ == OW'(1));
    wr_entry.addr   = pixel_addr(vga_x, vga_y, H_RES);
    wr_entry.colour = vga_colour;
  end

  // Saturating reject counters.
  always_comb begin
    drop_d = drop_q;
    oob_d  = oob_q;
    if (drop_hit && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
    if (oob_hit && (oob_q != {CNT_W{1'b1}}))   oob_d  = oob_q + CNT_W'(1);
  end

  // Drain FSM next-state; pulse is registered on entry to DONE.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty || last_pop) begin
          state_d      = DONE;
          drain_done_d = 1'b1;
        end
      end
      DONE: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, pulse and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
      drop_q       <= '0;
      oob_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      drop_q       <= drop_d;
      oob_q        <= oob_d;
    end
  end

  assign fb_we      = !empty;
  assign fb_addr    = head.addr;
  assign fb_data    = head.colour;
  assign busy       = !empty;
  assign full       = fifo_full;
  assign drain_done = drain_done_q;
  assign drop_count = drop_q;
  assign oob_count  = oob_q;

endmodule

// File: tb/tb_plot_queue.sv
// Bench for plot_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_plot_queue;

  logic        clk, rst;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we, fb_ready, drain_req, drain_done, busy, full;
  logic [15:0] drop_count, oob_count;

  plot_queue dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy       (busy),
    .full       (full),
    .drop_count (drop_count),
    .oob_count  (oob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int col;
  } ent_t;

  // Reference model: pending writes, counters, drain mode (0 run, 1 draining, 2 done).
  ent_t exp_q[$];
  int   m_drop, m_oob, m_mode;
  bit   m_pulse;
  int   n_checks, n_fail;

  // Apply one cycle of inputs, advance the model by the spec rules, step past the edge.
  task automatic tick(input bit plot, input int x, input int y, input int col,
                      input bit ready, input bit drain);
    int   sz;
    bit   inr, pop, push;
    ent_t e;
    vga_plot   = plot;
    vga_x      = 9'(x);
    vga_y      = 8'(y);
    vga_colour = 3'(col);
    fb_ready   = ready;
    drain_req  = drain;
    sz   = exp_q.size();
    pop  = (sz > 0) && ready;
    inr  = (x < 320) && (y < 240);
    push = plot && inr && ((sz < 16) || pop);
    m_pulse = 1'b0;
    if (plot && !inr && m_oob < 65535) m_oob++;
    if (plot && inr && !push && m_drop < 65535) m_drop++;
    case (m_mode)
      0: if (drain) m_mode = 1;
      1: if (sz == 0 || (pop && sz == 1 && !push)) begin m_mode = 2; m_pulse = 1'b1; end
      default: if (!drain) m_mode = 0;
    endcase
    if (pop) e = exp_q.pop_front();
    if (push) begin
      e.addr = y * 320 + x;
      e.col  = col;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
    fb_ready = 1'b0; drain_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_drop = 0; m_oob = 0; m_mode = 0; m_pulse = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", fb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
    n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", drain_done); end
    n_checks++; if (drop_count !== 16'd0 || oob_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got drop=%0d oob=%0d want 0/0", drop_count, oob_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tick(1, 5, 2, 3, 1, 0);
    n_checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd645 || fb_data !== 3'd3) begin
      n_fail++; $display("FAIL basic_write: got we=%0b addr=%0d data=%0d want 1/645/3", fb_we, fb_addr, fb_data);
    end
    tick(0, 0, 0, 0, 1, 0);
    n_checks++; if (busy !== 1'b0 || fb_we !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got busy=%0b we=%0b want 0/0", busy, fb_we);
    end
  endtask

  task automatic test_overflow();
    int first;
    do_reset();
    for (int i = 0; i < 16; i++)
      tick(1, int'($urandom_range(319, 0)), int'($urandom_range(239, 0)), int'($urandom_range(7, 0)), 0, 0);
    n_checks++; if (full !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full: got full=%0b busy=%0b want 1/1", full, busy);
    end
    tick(1, 10, 10, 1, 0, 0);
    n_checks++; if (drop_count !== 16'd1 || full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop: got drop=%0d full=%0b want 1/1", drop_count, full);
    end
    first = exp_q[0].addr;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      n_checks++; if (int'(fb_addr) != first || fb_we !== 1'b1) begin
        n_fail++; $display("FAIL ovf_stall_hold: got addr=%0d we=%0b want %0d/1", fb_addr, fb_we, first);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (fb_we !== 1'b1 || int'(fb_addr) != exp_q[0].addr || int'(fb_data) != exp_q[0].col) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got we=%0b addr=%0d data=%0d want 1/%0d/%0d",
                           i, fb_we, fb_addr, fb_data, exp_q[0].addr, exp_q[0].col);
      end
      tick(0, 0, 0, 0, 1, 0);
    end
    n_checks++; if (fb_we !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: got we=%0b full=%0b want 0/0", fb_we, full);
    end
  endtask

  task automatic test_oob();
    do_reset();
    tick(1, 320, 0, 1, 0, 0);
    tick(1, 0, 240, 2, 0, 0);
    tick(1, 319, 239, 4, 0, 0);
    n_checks++; if (oob_count !== 16'd2 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL oob_cnt: got oob=%0d drop=%0d want 2/0", oob_count, drop_count);
    end
    n_checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd76799 || fb_data !== 3'd4) begin
      n_fail++; $display("FAIL oob_corner: got we=%0b addr=%0d data=%0d want 1/76799/4", fb_we, fb_addr, fb_data);
    end
    tick(0, 0, 0, 0, 1, 0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oob_single: got busy=%0b want 0", busy); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, i, i, i % 8, 0, 0);
    tick(1, 7, 9, 5, 1, 0);
    n_checks++; if (full !== 1'b1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL fpp_accept: got full=%0b drop=%0d want 1/0", full, drop_count);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (fb_we !== 1'b1 || int'(fb_addr) != exp_q[0].addr || int'(fb_data) != exp_q[0].col) begin
        n_fail++; $display("FAIL fpp_order[%0d]: got addr=%0d data=%0d want %0d/%0d",
                           i, fb_addr, fb_data, exp_q[0].addr, exp_q[0].col);
      end
      if (i == 15) begin
        n_checks++; if (fb_addr !== 17'd2887) begin
          n_fail++; $display("FAIL fpp_last: got addr=%0d want 2887", fb_addr);
        end
      end
      tick(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_drain();
    int  pulses, pulse_cyc, empty_cyc;
    bit  rdy;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, i * 3, i + 1, i + 1, 0, 0);
    pulses = 0; pulse_cyc = -1; empty_cyc = -1; rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0, 0, rdy, 1);
      rdy = !rdy;
      if (empty_cyc < 0 && exp_q.size() == 0) empty_cyc = c;
      n_checks++; if (drain_done !== m_pulse) begin
        n_fail++; $display("FAIL drain_pulse[%0d]: got %0b want %0b", c, drain_done, m_pulse);
      end
      if (drain_done === 1'b1) begin pulses++; pulse_cyc = c; end
    end
    n_checks++; if (pulses != 1 || pulse_cyc != empty_cyc) begin
      n_fail++; $display("FAIL drain_once: got pulses=%0d at cycle %0d want 1 at cycle %0d", pulses, pulse_cyc, empty_cyc);
    end
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 1);
    n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_empty_1: got %0b want 0", drain_done); end
    tick(0, 0, 0, 0, 1, 1);
    n_checks++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL drain_empty_2: got %0b want 1", drain_done); end
    tick(0, 0, 0, 0, 1, 1);
    n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got %0b want 0", drain_done); end
    tick(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit rdy, plt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = (c < 200) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      plt = ($urandom_range(4, 0) != 0);
      tick(plt, int'($urandom_range(330, 0)), int'($urandom_range(250, 0)), int'($urandom_range(7, 0)), rdy, 0);
      n_checks++; if (fb_we !== (exp_q.size() > 0) || busy !== (exp_q.size() > 0) || full !== (exp_q.size() == 16)) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got we=%0b busy=%0b full=%0b want occupancy %0d",
                           c, fb_we, busy, full, exp_q.size());
      end
      n_checks++; if (int'(drop_count) != m_drop || int'(oob_count) != m_oob) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got drop=%0d oob=%0d want %0d/%0d", c, drop_count, oob_count, m_drop, m_oob);
      end
      if (exp_q.size() > 0) begin
        n_checks++; if (int'(fb_addr) != exp_q[0].addr || int'(fb_data) != exp_q[0].col) begin
          n_fail++; $display("FAIL rand_head[%0d]: got addr=%0d data=%0d want %0d/%0d",
                             c, fb_addr, fb_data, exp_q[0].addr, exp_q[0].col);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick(1, 320, 5, 1, 0, 0);
    for (int i = 0; i < 8; i++) tick(1, i + 20, i, 2, 0, 0);
    do_reset();
    n_checks++; if (fb_we !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got we=%0b busy=%0b full=%0b want 0/0/0", fb_we, busy, full);
    end
    n_checks++; if (drop_count !== 16'd0 || oob_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt: got drop=%0d oob=%0d want 0/0", drop_count, oob_count);
    end
    tick(1, 1, 1, 6, 1, 0);
    n_checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd321 || fb_data !== 3'd6) begin
      n_fail++; $display("FAIL rst_mid_write: got we=%0b addr=%0d data=%0d want 1/321/6", fb_we, fb_addr, fb_data);
    end
    tick(0, 0, 0, 0, 1, 0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got busy=%0b want 0", busy); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
    fb_ready = 1'b0; drain_req = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_oob();
    test_full_push_pop();
    test_drain();
    test_random();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
